mixer_decimator: RTL and testbench
==================================

// Module: mixer_decimator
// PURPOSE
//   Integrate-and-dump low-pass decimator directly downstream of the LO mixer stage.
//   Consumes the mixer's offset-binary output samples (data_in/dval_in ← mixer data_out/drdy_out).
//   Sums 2**DECIM_LOG2 consecutive valid samples as signed values, then emits one result per window:
//     - the window sum
//     - the window mean, re-offset to offset binary
//   Removes the 2f mixing product and cuts the rate handed to the detector/magnitude stage.
// PARAMETERS
//   DW          12  sample width, in and out (offset binary, midscale 2**(DW-1) = zero)
//   DECIM_LOG2  6   log2 of window length N (N = 64 by default); must be >= 1
// PORTS
//   clk       in   1                 system clock; all logic on posedge
//   rst       in   1                 synchronous, active-high reset
//   data_in   in   DW                mixer output sample, offset binary
//   dval_in   in   1                 data_in valid this cycle; may be high back-to-back
//   sync_clr  in   1                 discard partial window, restart count (synchronous)
//   data_out  out  DW                window mean, offset binary (registered)
//   sum_out   out  DW+DECIM_LOG2     window sum, two's complement (registered)
//   drdy_out  out  1                 1-cycle pulse: data_out/sum_out updated
// BEHAVIOUR
//   Reset values
//     rst=1 → acc=0, cnt=0, sum_out=0, data_out=2**(DW-1) (midscale), drdy_out=0.
//     rst has priority over every other input.
//   Input conversion
//     x = data_in with MSB inverted, taken as signed DW bits (= data_in - 2**(DW-1)).
//   Accumulator and counter
//     acc: signed DW+DECIM_LOG2 bits; cannot overflow (N*|min| fits exactly); no saturation logic.
//     cnt: DECIM_LOG2 bits, counts samples accepted in the current window.
//   Per clock, priority order
//     1. sync_clr=1 → acc=0, cnt=0, drdy_out=0. A dval_in in the same cycle is dropped.
//        data_out/sum_out hold their last values.
//     2. dval_in=1, cnt<N-1 → acc+=x, cnt+=1, drdy_out=0.
//     3. dval_in=1, cnt==N-1 (window complete)
//          s = acc + x
//          sum_out  <= s
//          data_out <= (s >>> DECIM_LOG2)[DW-1:0] with MSB inverted
//                      (arithmetic shift → floor toward -inf)
//          drdy_out <= 1
//          acc <= 0, cnt <= 0 (next window starts on the next sample; no gap)
//     4. otherwise → acc/cnt hold, drdy_out=0.
//   Timing
//     Latency: drdy_out is high on the cycle after the edge that captured the Nth sample.
//     Outputs stay stable until the next completed window.
//     Throughput: one sample per clock sustained; gaps in dval_in are allowed at any point
//       and do not affect the result.
//     drdy_out is never high on two consecutive cycles (N >= 2).
//   Reset mid-window: partial window discarded, outputs return to reset values.
// TESTING (DW=12, DECIM_LOG2=2, so N=4, sum 14 bits)
//   1. Reset
//      Assert rst 2 cycles → data_out=0x800, sum_out=0, drdy_out=0.
//      Then 10 idle cycles → no drdy_out.
//   2. Back-to-back 0x801
//      4 samples of 0x801, dval_in high 4 cycles → sum_out=4, data_out=0x801.
//      Single drdy_out pulse on the cycle after the 4th sample.
//   3. Extremes
//      4×0x000 → sum_out=-8192 (0x2000), data_out=0x000.
//      Then 4×0xFFF → sum_out=8188, data_out=0xFFF.
//   4. Floor rounding
//      Samples 0x7FF,0x800,0x800,0x800 → sum_out=-1, data_out=0x7FF (not 0x800).
//   5. sync_clr
//      2 samples of 0xFFF, then sync_clr=1 with dval_in=1 (data 0xFFF).
//      Then 4×0x900 → exactly one drdy_out: sum_out=1024, data_out=0x900.
//   6. Gaps and reset mid-window
//      Gapped dval_in (every 3rd cycle), 4×0x804 → sum_out=16, data_out=0x804.
//      Then 3 samples, rst for 1 cycle, 4×0x7FC → sum_out=-16, data_out=0x7FC.

Source files
------------

// File: rtl/mixer_decimator.sv
// Integrate-and-dump decimator: sums 2**DECIM_LOG2 offset-binary samples as signed values and
// emits the window sum plus the floor mean re-offset to offset binary.
module mixer_decimator #(
  parameter int unsigned DW         = 12,
  parameter int unsigned DECIM_LOG2 = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW-1:0]              data_in,
  input  logic                       dval_in,
  input  logic                       sync_clr,
  output logic [DW-1:0]              data_out,
  output logic [DW+DECIM_LOG2-1:0]   sum_out,
  output logic                       drdy_out
);

  localparam int unsigned SW = DW + DECIM_LOG2;

  logic signed [SW-1:0]   acc_q, acc_d;
  logic [DECIM_LOG2-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]          data_q, data_d;
  logic [SW-1:0]          sum_q, sum_d;
  logic                   drdy_q, drdy_d;

  logic signed [SW-1:0]   x_ext;
  logic signed [SW-1:0]   s;
  logic [DW-1:0]          mean;
  logic                   win_last;

  // Inverting the MSB turns offset binary into two's complement; then sign-extend.
  assign x_ext = {{DECIM_LOG2{~data_in[DW-1]}}, ~data_in[DW-1], data_in[DW-2:0]};
  assign s     = acc_q + x_ext;

  // Dropping the low DECIM_LOG2 bits of a two's-complement value is a floor division by N.
  assign mean     = s[SW-1:DECIM_LOG2];
  assign win_last = (cnt_q == {DECIM_LOG2{1'b1}});

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    sum_d  = sum_q;
    drdy_d = 1'b0;
    if (sync_clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (dval_in) begin
      if (win_last) begin
        sum_d  = s;
        data_d = {~mean[DW-1], mean[DW-2:0]};
        drdy_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = s;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      data_q <= {1'b1, {(DW-1){1'b0}}};
      sum_q  <= '0;
      drdy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      sum_q  <= sum_d;
      drdy_q <= drdy_d;
    end
  end

  assign data_out = data_q;
  assign sum_out  = sum_q;
  assign drdy_out = drdy_q;

endmodule

// File: tb/tb_mixer_decimator.sv
// Bench for mixer_decimator (DW=12, N=4): directed cases with literal expectations, then random
// traffic compared every cycle against an arithmetic window model.
module tb_mixer_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] data_in = '0;
  logic        dval_in = 1'b0;
  logic        sync_clr = 1'b0;
  logic [11:0] data_out;
  logic [13:0] sum_out;
  logic        drdy_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit compare_en = 1'b0;

  mixer_decimator #(.DW(12), .DECIM_LOG2(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .dval_in  (dval_in),
    .sync_clr (sync_clr),
    .data_out (data_out),
    .sum_out  (sum_out),
    .drdy_out (drdy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: collect accepted samples as signed integers; a full window yields sum and floor mean.
  int          win_vals[$];
  int          exp_sum  = 0;
  logic [11:0] exp_data = 12'h800;
  logic        exp_drdy = 1'b0;

  function automatic int floor_div4(input int v);
    if (v >= 0) return v / 4;
    return -((-v + 3) / 4);
  endfunction

  always @(posedge clk) begin
    exp_drdy = 1'b0;
    if (rst) begin
      win_vals.delete();
      exp_sum  = 0;
      exp_data = 12'h800;
    end else if (sync_clr) begin
      win_vals.delete();
    end else if (dval_in) begin
      win_vals.push_back(int'(data_in) - 2048);
      if (win_vals.size() == 4) begin
        exp_sum = 0;
        foreach (win_vals[i]) exp_sum += win_vals[i];
        exp_data = 12'(floor_div4(exp_sum) + 2048);
        exp_drdy = 1'b1;
        win_vals.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      check("model_drdy", {31'b0, drdy_out}, {31'b0, exp_drdy});
      check("model_sum", {{18{sum_out[13]}}, sum_out}, 32'(exp_sum));
      check("model_data", {20'b0, data_out}, {20'b0, exp_data});
    end
  end

  // Inputs change on the falling edge, away from the capturing rising edge.
  task automatic step(input logic [11:0] d, input logic v, input logic c, input logic r);
    @(negedge clk);
    data_in  = d;
    dval_in  = v;
    sync_clr = c;
    rst      = r;
  endtask

  task automatic idle();
    step(12'h000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic samples(input logic [11:0] d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b1, 1'b0, 1'b0);
  endtask

  // Called on the cycle right after the last sample of a window.
  task automatic expect_window(input string name, input int sum, input logic [11:0] data);
    idle();
    check({name, "_drdy"}, {31'b0, drdy_out}, 32'd1);
    check({name, "_sum"}, {{18{sum_out[13]}}, sum_out}, 32'(sum));
    check({name, "_data"}, {20'b0, data_out}, {20'b0, data});
  endtask

  initial begin
    int drdy_seen;
    logic [11:0] rd;

    // 1. Reset
    step(12'h000, 1'b0, 1'b0, 1'b1);
    step(12'h000, 1'b0, 1'b0, 1'b1);
    idle();
    compare_en = 1'b1;
    check("reset_data", {20'b0, data_out}, 32'h800);
    check("reset_sum", {18'b0, sum_out}, 32'd0);
    check("reset_drdy", {31'b0, drdy_out}, 32'd0);
    drdy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (drdy_out !== 1'b0) drdy_seen++;
    end
    check("idle_no_drdy", 32'(drdy_seen), 32'd0);

    // 2. Back-to-back 0x801
    samples(12'h801, 4);
    expect_window("b2b", 4, 12'h801);
    idle();
    check("b2b_single_pulse", {31'b0, drdy_out}, 32'd0);

    // 3. Extremes, back to back
    samples(12'h000, 4);
    expect_window("min", -8192, 12'h000);
    samples(12'hFFF, 4);
    expect_window("max", 8188, 12'hFFF);

    // 4. Floor rounding
    step(12'h7FF, 1'b1, 1'b0, 1'b0);
    samples(12'h800, 3);
    expect_window("floor", -1, 12'h7FF);

    // 5. sync_clr drops the partial window and the coincident sample
    samples(12'hFFF, 2);
    step(12'hFFF, 1'b1, 1'b1, 1'b0);
    drdy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(12'h900, 1'b1, 1'b0, 1'b0);
      if (drdy_out === 1'b1) drdy_seen++;
    end
    expect_window("clr", 1024, 12'h900);
    check("clr_pulse_count", 32'(drdy_seen), 32'd0);

    // 6. Gapped input, then reset mid-window
    for (int i = 0; i < 4; i++) begin
      step(12'h804, 1'b1, 1'b0, 1'b0);
      if (i < 3) begin
        idle();
        idle();
      end
    end
    expect_window("gap", 16, 12'h804);
    samples(12'h123, 3);
    step(12'h123, 1'b1, 1'b0, 1'b1);
    idle();
    check("midrst_data", {20'b0, data_out}, 32'h800);
    check("midrst_sum", {18'b0, sum_out}, 32'd0);
    samples(12'h7FC, 4);
    expect_window("post_rst", -16, 12'h7FC);

    // Random traffic: the per-cycle comparison does the checking
    for (int i = 0; i < 3000; i++) begin
      rd = 12'($urandom);
      case ($urandom_range(0, 3))
        0: rd = 12'h000;
        1: rd = 12'hFFF;
        default: ;
      endcase
      step(rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 199) == 0));
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
